// File: rtl/clic_target_pipe.sv
// clic_target_pipe
//   Selects the highest-priority pending and enabled CLIC source with a binary max-tree. The
//   tree can be registered every PipeStride levels. The winner is gated by the threshold of
//   its privilege mode and then offered to the core. The offer uses a valid/ready handshake
//   and a kill_req/kill_ack handshake for preemption. An accepted offer produces a one-cycle
//   one-hot claim pulse.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ip_i, ie_i           per-source pending / enable
//   le_i                 per-source trigger type (1 = edge, 0 = level)
//   shv_i                per-source selective hardware vectoring
//   prio_i, mode_i       per-source priority and privilege mode, packed source 0 at LSB
//   m/s/uthresh_i        per-privilege interrupt thresholds
//   claim_o              one-hot claim pulse, clears edge pending upstream
//   irq_valid_o          offer valid; irq_ready_i is the core's accept
//   irq_id/max/mode/shv_o offered source id, priority, mode and SHV bit
//   irq_kill_req_o       request to withdraw the offer; irq_kill_ack_i grants it
module clic_target_pipe #(
    parameter int unsigned N_SOURCE   = 256,
    parameter int unsigned PrioWidth  = 8,
    parameter int unsigned ModeWidth  = 2,
    parameter int unsigned PipeStride = 0,
    localparam int unsigned SrcWidth  = $clog2(N_SOURCE)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_SOURCE-1:0]             ip_i,
    input  logic [N_SOURCE-1:0]             ie_i,
    input  logic [N_SOURCE-1:0]             le_i,
    input  logic [N_SOURCE-1:0]             shv_i,
    input  logic [N_SOURCE*PrioWidth-1:0]   prio_i,
    input  logic [N_SOURCE*ModeWidth-1:0]   mode_i,
    input  logic [PrioWidth-1:0]            mthresh_i,
    input  logic [PrioWidth-1:0]            sthresh_i,
    input  logic [PrioWidth-1:0]            uthresh_i,
    output logic [N_SOURCE-1:0]             claim_o,
    output logic                            irq_valid_o,
    input  logic                            irq_ready_i,
    output logic [SrcWidth-1:0]             irq_id_o,
    output logic [PrioWidth-1:0]            irq_max_o,
    output logic [ModeWidth-1:0]            irq_mode_o,
    output logic                            irq_shv_o,
    output logic                            irq_kill_req_o,
    input  logic                            irq_kill_ack_i
);

    localparam int unsigned NumLevels = $clog2(N_SOURCE);
    localparam int unsigned NumLeaves = 1 << NumLevels;
    localparam int unsigned Stride    = (PipeStride == 0) ? 1 : PipeStride;
    localparam int unsigned KeyWidth  = ModeWidth + PrioWidth;

    localparam logic [ModeWidth-1:0] ModeM        = ModeWidth'(2'b11);
    localparam logic [ModeWidth-1:0] ModeS        = ModeWidth'(2'b01);
    localparam logic [ModeWidth-1:0] ModeReserved = ModeWidth'(2'b10);

    typedef struct packed {
        logic                valid;
        logic [KeyWidth-1:0] key;   // {mode, prio}
        logic                shv;
        logic [SrcWidth-1:0] id;
    } node_t;

    typedef enum logic [1:0] {StIdle, StCheck, StAck, StClaim} state_e;

    // A register follows every Stride levels counted from the leaves, and the root is always
    // registered when pipelining is enabled at all.
    function automatic logic reg_after(int unsigned lvl);
        return (PipeStride != 0) && (lvl != 0) && ((lvl % Stride == 0) || (lvl == NumLevels));
    endfunction

    node_t tree_c [NumLevels+1][NumLeaves];
    node_t pipe_q [NumLevels+1][NumLeaves];
    node_t root;

    // ---------------------------------------------------------------------------------------
    // Max tree
    // ---------------------------------------------------------------------------------------
    always_comb begin
        node_t c0;
        node_t c1;
        for (int l = 0; l <= int'(NumLevels); l++) begin
            for (int k = 0; k < int'(NumLeaves); k++) begin
                tree_c[l][k] = '0;
            end
        end
        // Leaves past N_SOURCE stay zero, i.e. invalid.
        for (int k = 0; k < int'(N_SOURCE); k++) begin
            tree_c[0][k].valid = ip_i[k] & ie_i[k]
                               & (mode_i[k*ModeWidth +: ModeWidth] != ModeReserved);
            tree_c[0][k].key   = {mode_i[k*ModeWidth +: ModeWidth], prio_i[k*PrioWidth +: PrioWidth]};
            tree_c[0][k].shv   = shv_i[k];
            tree_c[0][k].id    = SrcWidth'(k);
        end
        for (int l = 1; l <= int'(NumLevels); l++) begin
            for (int k = 0; k < int'(NumLeaves >> l); k++) begin
                c0 = reg_after(l - 1) ? pipe_q[l-1][2*k]   : tree_c[l-1][2*k];
                c1 = reg_after(l - 1) ? pipe_q[l-1][2*k+1] : tree_c[l-1][2*k+1];
                // Lower id (c0) wins ties; two invalid children yield an invalid c0.
                if (c0.valid && c1.valid) begin
                    tree_c[l][k] = (c1.key > c0.key) ? c1 : c0;
                end else if (c1.valid) begin
                    tree_c[l][k] = c1;
                end else begin
                    tree_c[l][k] = c0;
                end
            end
        end
    end

    // Only the stages selected by reg_after() feed the tree; the rest are never read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l <= int'(NumLevels); l++) begin
                for (int k = 0; k < int'(NumLeaves); k++) begin
                    pipe_q[l][k] <= '0;
                end
            end
        end else begin
            for (int l = 0; l <= int'(NumLevels); l++) begin
                for (int k = 0; k < int'(NumLeaves); k++) begin
                    pipe_q[l][k] <= tree_c[l][k];
                end
            end
        end
    end

    assign root = reg_after(NumLevels) ? pipe_q[NumLevels][0] : tree_c[NumLevels][0];

    // ---------------------------------------------------------------------------------------
    // Threshold gate
    // ---------------------------------------------------------------------------------------
    logic [ModeWidth-1:0] root_mode;
    logic [PrioWidth-1:0] root_prio;
    logic [PrioWidth-1:0] root_thresh;
    logic                 root_ok;

    assign root_mode = root.key[KeyWidth-1 -: ModeWidth];
    assign root_prio = root.key[PrioWidth-1:0];

    always_comb begin
        root_thresh = uthresh_i;
        if (root_mode == ModeM) begin
            root_thresh = mthresh_i;
        end else if (root_mode == ModeS) begin
            root_thresh = sthresh_i;
        end
    end

    // Strict compare, so a priority of 0 can never pass.
    assign root_ok = root.valid && (root_prio > root_thresh);

    // ---------------------------------------------------------------------------------------
    // Handoff FSM
    // ---------------------------------------------------------------------------------------
    state_e               state_q;
    logic [SrcWidth-1:0]  id_q;
    logic [PrioWidth-1:0] max_q;
    logic [ModeWidth-1:0] mode_q;
    logic                 shv_q;
    logic                 valid_q;
    logic                 kill_q;
    logic [N_SOURCE-1:0]  claim_q;
    logic                 preempt;

    assign preempt = root_ok && (root.key > {mode_q, max_q});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            id_q    <= '0;
            max_q   <= '0;
            mode_q  <= '0;
            shv_q   <= 1'b0;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            claim_q <= '0;
        end else begin
            claim_q <= '0;
            unique case (state_q)
                StIdle: begin
                    // The root may lag the inputs; StCheck filters out stale winners.
                    if (root_ok) begin
                        id_q    <= root.id;
                        max_q   <= root_prio;
                        mode_q  <= root_mode;
                        shv_q   <= root.shv;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (ip_i[id_q] && ie_i[id_q]) begin
                        valid_q <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAck: begin
                    if (!le_i[id_q] && !ip_i[id_q]) begin
                        // Level source deasserted: withdraw silently.
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (irq_ready_i) begin
                        // Acceptance beats a simultaneous kill_ack.
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        claim_q <= N_SOURCE'(1) << id_q;
                        state_q <= StClaim;
                    end else if (kill_q && irq_kill_ack_i) begin
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (preempt) begin
                        // Once raised, kill_req is never retracted.
                        kill_q  <= 1'b1;
                    end
                end
                StClaim: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign claim_o        = claim_q;
    assign irq_valid_o    = valid_q;
    assign irq_id_o       = id_q;
    assign irq_max_o      = max_q;
    assign irq_mode_o     = mode_q;
    assign irq_shv_o      = shv_q;
    assign irq_kill_req_o = kill_q;

endmodule

// File: tb/tb_clic_target_pipe.sv
module tb_clic_target_pipe;

    localparam int NA = 8;
    localparam int NB = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N=8, combinational tree
    logic [NA-1:0]   a_ip, a_ie, a_le, a_shv;
    logic [NA*8-1:0] a_prio;
    logic [NA*2-1:0] a_mode;
    logic [7:0]      a_mth, a_sth, a_uth;
    logic            a_ready, a_kack;
    logic [NA-1:0]   a_claim;
    logic            a_valid, a_shvo, a_kill;
    logic [2:0]      a_id;
    logic [7:0]      a_max;
    logic [1:0]      a_modeo;

    // Instance B: N=256, register every 2 levels (4 pipeline stages)
    logic [NB-1:0]   b_ip, b_ie, b_le, b_shv;
    logic [NB*8-1:0] b_prio;
    logic [NB*2-1:0] b_mode;
    logic [7:0]      b_mth, b_sth, b_uth;
    logic            b_ready, b_kack;
    logic [NB-1:0]   b_claim;
    logic            b_valid, b_shvo, b_kill;
    logic [7:0]      b_id;
    logic [7:0]      b_max;
    logic [1:0]      b_modeo;

    clic_target_pipe #(.N_SOURCE(NA), .PrioWidth(8), .ModeWidth(2), .PipeStride(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .ip_i(a_ip), .ie_i(a_ie), .le_i(a_le), .shv_i(a_shv),
        .prio_i(a_prio), .mode_i(a_mode), .mthresh_i(a_mth), .sthresh_i(a_sth),
        .uthresh_i(a_uth), .claim_o(a_claim), .irq_valid_o(a_valid), .irq_ready_i(a_ready),
        .irq_id_o(a_id), .irq_max_o(a_max), .irq_mode_o(a_modeo), .irq_shv_o(a_shvo),
        .irq_kill_req_o(a_kill), .irq_kill_ack_i(a_kack)
    );

    clic_target_pipe #(.N_SOURCE(NB), .PrioWidth(8), .ModeWidth(2), .PipeStride(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .ip_i(b_ip), .ie_i(b_ie), .le_i(b_le), .shv_i(b_shv),
        .prio_i(b_prio), .mode_i(b_mode), .mthresh_i(b_mth), .sthresh_i(b_sth),
        .uthresh_i(b_uth), .claim_o(b_claim), .irq_valid_o(b_valid), .irq_ready_i(b_ready),
        .irq_id_o(b_id), .irq_max_o(b_max), .irq_mode_o(b_modeo), .irq_shv_o(b_shvo),
        .irq_kill_req_o(b_kill), .irq_kill_ack_i(b_kack)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_a();
        a_ip = '0; a_ie = '0; a_le = '0; a_shv = '0; a_prio = '0; a_mode = '0;
        a_mth = '0; a_sth = '0; a_uth = '0; a_ready = 1'b0; a_kack = 1'b0;
    endtask

    task automatic clear_b();
        b_ip = '0; b_ie = '0; b_le = '0; b_shv = '0; b_prio = '0; b_mode = '0;
        b_mth = '0; b_sth = '0; b_uth = '0; b_ready = 1'b0; b_kack = 1'b0;
    endtask

    task automatic drain_a();
        clear_a();
        repeat (4) tick();
    endtask

    task automatic set_a(int s, bit ip, bit le, int mode, int prio);
        a_ip[s] = ip; a_ie[s] = 1'b1; a_le[s] = le;
        a_mode[2*s +: 2] = 2'(mode); a_prio[8*s +: 8] = 8'(prio);
    endtask

    // ---------------------------------------------------------------------------------------
    // Reference model for instance A: linear scan for the winner, transaction-level handoff.
    // ---------------------------------------------------------------------------------------
    int        m_ph;     // 0 idle, 1 re-check, 2 offered, 3 claiming
    int        m_id, m_key;
    bit        m_shv, m_valid, m_kill;
    logic [7:0] m_claim;

    function automatic void winner(output bit ok, output int id, output int key, output bit shv);
        int best = -1;
        int th;
        ok = 0; id = 0; key = 0; shv = 0;
        for (int s = 0; s < NA; s++) begin
            int md = int'(a_mode[2*s +: 2]);
            int pr = int'(a_prio[8*s +: 8]);
            if (a_ip[s] && a_ie[s] && md != 2 && md * 256 + pr > best) begin
                best = md * 256 + pr; id = s; shv = a_shv[s];
            end
        end
        if (best >= 0) begin
            key = best;
            th  = (best / 256 == 3) ? int'(a_mth) : (best / 256 == 1) ? int'(a_sth) : int'(a_uth);
            ok  = (best % 256) > th;
        end
    endfunction

    task automatic model_step();
        bit ok, wshv;
        int wid, wkey;
        winner(ok, wid, wkey, wshv);
        case (m_ph)
            0: if (ok) begin m_id = wid; m_key = wkey; m_shv = wshv; m_ph = 1; end
            1: if (a_ip[m_id] && a_ie[m_id]) begin m_ph = 2; m_valid = 1; end else m_ph = 0;
            2: begin
                if (!a_le[m_id] && !a_ip[m_id]) begin m_ph = 0; m_valid = 0; m_kill = 0; end
                else if (a_ready) begin
                    m_ph = 3; m_valid = 0; m_kill = 0; m_claim = 8'(1 << m_id);
                end
                else if (m_kill && a_kack) begin m_ph = 0; m_valid = 0; m_kill = 0; end
                else if (ok && wkey > m_key) m_kill = 1;
            end
            default: begin m_claim = '0; m_ph = 0; end
        endcase
    endtask

    // ---------------------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; clear_a(); clear_b();
        #3;
        n_vec++;
        if ({a_claim, a_valid, a_id, a_max, a_modeo, a_shvo, a_kill} !== '0) begin
            n_err++; $display("FAIL reset_a: got claim=%h valid=%b id=%0d kill=%b want all 0",
                              a_claim, a_valid, a_id, a_kill);
        end
        n_vec++;
        if ({b_claim, b_valid, b_id, b_max, b_modeo, b_shvo, b_kill} !== '0) begin
            n_err++; $display("FAIL reset_b: got valid=%b id=%0d kill=%b want all 0",
                              b_valid, b_id, b_kill);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_offer();  // T1
        set_a(5, 1, 1, 3, 3);
        tick();
        n_vec++;
        if (a_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_early: got %b want 0", a_valid); end
        tick();
        n_vec++;
        if ({a_valid, a_id, a_max, a_modeo} !== {1'b1, 3'd5, 8'd3, 2'b11}) begin
            n_err++; $display("FAIL t1_offer: got valid=%b id=%0d max=%0d mode=%0d want 1/5/3/3",
                              a_valid, a_id, a_max, a_modeo);
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        n_vec++;
        if ({a_claim, a_valid} !== {8'h20, 1'b0}) begin
            n_err++; $display("FAIL t1_claim: got claim=%h valid=%b want 20/0", a_claim, a_valid);
        end
        a_ip = '0;
        tick();
        n_vec++;
        if (a_claim !== 8'h00) begin n_err++; $display("FAIL t1_claim_once: got %h want 00", a_claim); end
        drain_a();
    endtask

    task automatic test_threshold();  // T2 plus threshold raised during an offer
        set_a(2, 1, 0, 1, 4);
        a_sth = 8'd4;
        repeat (4) tick();
        n_vec++;
        if (a_valid !== 1'b0) begin n_err++; $display("FAIL t2_equal_thresh: got %b want 0", a_valid); end
        a_sth = 8'd3;
        repeat (2) tick();
        n_vec++;
        if ({a_valid, a_id, a_modeo} !== {1'b1, 3'd2, 2'b01}) begin
            n_err++; $display("FAIL t2_offer: got valid=%b id=%0d mode=%0d want 1/2/1",
                              a_valid, a_id, a_modeo);
        end
        a_sth = 8'd200;
        tick();
        n_vec++;
        if ({a_valid, a_id} !== {1'b1, 3'd2}) begin
            n_err++; $display("FAIL t2_thresh_in_ack: got valid=%b id=%0d want 1/2", a_valid, a_id);
        end
        a_ready = 1'b1;
        tick();
        n_vec++;
        if (a_claim !== 8'h04) begin n_err++; $display("FAIL t2_claim: got %h want 04", a_claim); end
        drain_a();
    endtask

    task automatic test_preempt();  // T3
        set_a(1, 1, 0, 3, 2);
        repeat (2) tick();
        n_vec++;
        if ({a_valid, a_id} !== {1'b1, 3'd1}) begin
            n_err++; $display("FAIL t3_first: got valid=%b id=%0d want 1/1", a_valid, a_id);
        end
        set_a(6, 1, 0, 3, 9);
        tick();
        n_vec++;
        if ({a_kill, a_valid, a_id, a_max} !== {1'b1, 1'b1, 3'd1, 8'd2}) begin
            n_err++; $display("FAIL t3_kill_req: got kill=%b valid=%b id=%0d max=%0d want 1/1/1/2",
                              a_kill, a_valid, a_id, a_max);
        end
        a_kack = 1'b1;
        tick();
        a_kack = 1'b0;
        n_vec++;
        if ({a_kill, a_valid, a_claim} !== '0) begin
            n_err++; $display("FAIL t3_killed: got kill=%b valid=%b claim=%h want 0/0/00",
                              a_kill, a_valid, a_claim);
        end
        repeat (2) tick();
        n_vec++;
        if ({a_valid, a_id, a_max, a_claim} !== {1'b1, 3'd6, 8'd9, 8'h00}) begin
            n_err++; $display("FAIL t3_reoffer: got valid=%b id=%0d max=%0d claim=%h want 1/6/9/00",
                              a_valid, a_id, a_max, a_claim);
        end
        drain_a();
    endtask

    task automatic test_claim_beats_kill();  // T4
        set_a(3, 1, 0, 3, 5);
        set_a(7, 1, 0, 3, 5);
        repeat (2) tick();
        n_vec++;
        if ({a_valid, a_id} !== {1'b1, 3'd3}) begin
            n_err++; $display("FAIL t4_tie: got valid=%b id=%0d want 1/3", a_valid, a_id);
        end
        set_a(7, 1, 0, 3, 6);
        tick();
        n_vec++;
        if ({a_kill, a_id} !== {1'b1, 3'd3}) begin
            n_err++; $display("FAIL t4_kill_req: got kill=%b id=%0d want 1/3", a_kill, a_id);
        end
        a_ready = 1'b1; a_kack = 1'b1;
        tick();
        a_ready = 1'b0; a_kack = 1'b0;
        n_vec++;
        if ({a_claim, a_valid, a_kill} !== {8'h08, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL t4_claim_wins: got claim=%h valid=%b kill=%b want 08/0/0",
                              a_claim, a_valid, a_kill);
        end
        drain_a();
    endtask

    task automatic test_level_edge();  // T5
        set_a(4, 1, 0, 3, 1);
        repeat (2) tick();
        n_vec++;
        if ({a_valid, a_id} !== {1'b1, 3'd4}) begin
            n_err++; $display("FAIL t5_level_offer: got valid=%b id=%0d want 1/4", a_valid, a_id);
        end
        a_ip[4] = 1'b0;
        tick();
        n_vec++;
        if ({a_valid, a_kill, a_claim} !== '0) begin
            n_err++; $display("FAIL t5_level_drop: got valid=%b kill=%b claim=%h want 0/0/00",
                              a_valid, a_kill, a_claim);
        end
        tick();
        n_vec++;
        if (a_claim !== 8'h00) begin n_err++; $display("FAIL t5_no_claim: got %h want 00", a_claim); end
        drain_a();
        set_a(4, 1, 1, 3, 1);
        repeat (2) tick();
        a_ip[4] = 1'b0;
        tick();
        n_vec++;
        if ({a_valid, a_id} !== {1'b1, 3'd4}) begin
            n_err++; $display("FAIL t5_edge_hold: got valid=%b id=%0d want 1/4", a_valid, a_id);
        end
        a_ready = 1'b1;
        tick();
        n_vec++;
        if (a_claim !== 8'h10) begin n_err++; $display("FAIL t5_edge_claim: got %h want 10", a_claim); end
        drain_a();
    endtask

    task automatic test_pipelined();  // T6
        clear_b();
        b_mth = 8'd5; b_sth = 8'd5; b_uth = 8'd5;
        // Background sources that never clear their threshold.
        for (int s = 0; s < NB; s++) begin
            int md = $urandom_range(0, 2);
            b_ip[s] = 1'($urandom_range(0, 1)); b_ie[s] = 1'b1;
            b_mode[2*s +: 2] = (md == 2) ? 2'b11 : 2'(md);
            b_prio[8*s +: 8] = 8'($urandom_range(0, 5));
        end
        b_ie[200] = 1'b1; b_mode[400 +: 2] = 2'b11; b_prio[1600 +: 8] = 8'd7; b_shv[200] = 1'b1;
        b_ip[200] = 1'b1;
        repeat (2) tick();
        b_ip[200] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_vec++;
            if (b_valid !== 1'b0) begin n_err++; $display("FAIL t6_pulse t=%0d: got %b want 0", t, b_valid); end
        end
        b_ip[200] = 1'b1;
        repeat (5) tick();
        n_vec++;
        if (b_valid !== 1'b0) begin n_err++; $display("FAIL t6_latency_early: got %b want 0", b_valid); end
        tick();
        n_vec++;
        if ({b_valid, b_id, b_max, b_shvo} !== {1'b1, 8'd200, 8'd7, 1'b1}) begin
            n_err++; $display("FAIL t6_offer: got valid=%b id=%0d max=%0d shv=%b want 1/200/7/1",
                              b_valid, b_id, b_max, b_shvo);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        n_vec++;
        if (b_claim !== (NB'(1) << 200)) begin
            n_err++; $display("FAIL t6_claim: got bit200=%b popcount=%0d want 1/1",
                              b_claim[200], $countones(b_claim));
        end
        clear_b();
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        set_a(5, 1, 1, 3, 3);
        repeat (2) tick();
        set_a(6, 1, 1, 3, 8);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_valid, a_kill, a_claim, a_id} !== '0) begin
            n_err++; $display("FAIL async_reset: got valid=%b kill=%b claim=%h id=%0d want all 0",
                              a_valid, a_kill, a_claim, a_id);
        end
        @(negedge clk);
        clear_a();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({a_valid, a_claim} !== '0) begin
            n_err++; $display("FAIL async_reset_after: got valid=%b claim=%h want 0/00", a_valid, a_claim);
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0; clear_a();
        m_ph = 0; m_id = 0; m_key = 0; m_shv = 0; m_valid = 0; m_kill = 0; m_claim = '0;
        @(negedge clk); rst_n = 1'b1;
        a_ie = 8'($urandom); a_le = 8'($urandom);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) a_ip = 8'($urandom);
            if ($urandom_range(0, 49) == 0) a_ie = 8'($urandom);
            if ($urandom_range(0, 29) == 0) a_le = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                int s = $urandom_range(0, NA - 1);
                a_mode[2*s +: 2] = 2'($urandom_range(0, 3));
                a_prio[8*s +: 8] = 8'($urandom_range(0, 15));
                a_shv[s] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 29) == 0) begin
                a_mth = 8'($urandom_range(0, 6)); a_sth = 8'($urandom_range(0, 6));
                a_uth = 8'($urandom_range(0, 6));
            end
            a_ready = ($urandom_range(0, 3) == 0);
            a_kack  = 1'($urandom_range(0, 1));
            @(posedge clk);
            model_step();
            @(negedge clk);
            n_vec++;
            if ({a_valid, a_kill, a_claim} !== {m_valid, m_kill, m_claim}) begin
                n_err++; $display("FAIL rand_ctrl c=%0d: got valid=%b kill=%b claim=%h want %b/%b/%h",
                                  c, a_valid, a_kill, a_claim, m_valid, m_kill, m_claim);
            end
            n_vec++;
            if ({a_id, a_max, a_modeo, a_shvo} !== {3'(m_id), 8'(m_key % 256), 2'(m_key / 256), m_shv}) begin
                n_err++; $display("FAIL rand_data c=%0d: got id=%0d max=%0d mode=%0d shv=%b want %0d/%0d/%0d/%b",
                                  c, a_id, a_max, a_modeo, a_shvo, m_id, m_key % 256, m_key / 256, m_shv);
            end
        end
        drain_a();
    endtask

    initial begin
        test_reset();
        test_basic_offer();
        test_threshold();
        test_preempt();
        test_claim_beats_kill();
        test_level_edge();
        test_pipelined();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
